control_unit: RTL

Multicycle controller for the 16-bit RiSC-16-style datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the register-file select and write-enable lines (MUX_tgt, MUX_rf, WE_rf), the PC and IR write enables, the ALU controls and a request/ready memory handshake. It sits beside the register file and ALU inside the CPU top and is the only source of datapath control.

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/instr_decode.sv | 34 +++
 rtl/control_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared opcodes, controller state and instruction-class enums, and
//          the MUX_tgt / MUX_pc / alu_op encodings used by the datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  // Opcode field instruction[15:13]
  localparam logic [2:0] c_OP_ADD  = 3'b000;
  localparam logic [2:0] c_OP_ADDI = 3'b001;
  localparam logic [2:0] c_OP_NAND = 3'b010;
  localparam logic [2:0] c_OP_LUI  = 3'b011;
  localparam logic [2:0] c_OP_SW   = 3'b100;
  localparam logic [2:0] c_OP_LW   = 3'b101;
  localparam logic [2:0] c_OP_BEQ  = 3'b110;
  localparam logic [2:0] c_OP_JALR = 3'b111;

  // Register-file write source
  localparam logic [1:0] c_TGT_MEM = 2'b00;
  localparam logic [1:0] c_TGT_ALU = 2'b01;
  localparam logic [1:0] c_TGT_PC1 = 2'b10;

  // Next-PC source
  localparam logic [1:0] c_PC_INC    = 2'b00;
  localparam logic [1:0] c_PC_BRANCH = 2'b01;
  localparam logic [1:0] c_PC_REG    = 2'b10;

  // ALU operations
  localparam logic [1:0] c_ALU_ADD    = 2'b00;
  localparam logic [1:0] c_ALU_NAND   = 2'b01;
  localparam logic [1:0] c_ALU_PASS_B = 2'b10;
  localparam logic [1:0] c_ALU_EQ     = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU_RRR = 3'd0,
    CLS_ALU_IMM = 3'd1,
    CLS_LUI     = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_BRANCH  = 3'd5,
    CLS_JALR    = 3'd6,
    CLS_HALT    = 3'd7
  } instr_class_t;

endpackage

`default_nettype wire

// File: rtl/instr_decode.sv
// ============================================================================
// Module : instr_decode
// Brief  : Combinational opcode/simm7 to instruction-class mapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_decode
  import cpu_pkg::*;
(
  input  logic [2:0]   opcode,
  input  logic [6:0]   simm7,
  output instr_class_t instr_class
);

  // Classify the instruction; JALR with a non-zero immediate encodes HALT
  always_comb begin
    instr_class = CLS_ALU_RRR;
    case (opcode)
      c_OP_ADD,
      c_OP_NAND: instr_class = CLS_ALU_RRR;
      c_OP_ADDI: instr_class = CLS_ALU_IMM;
      c_OP_LUI:  instr_class = CLS_LUI;
      c_OP_SW:   instr_class = CLS_STORE;
      c_OP_LW:   instr_class = CLS_LOAD;
      c_OP_BEQ:  instr_class = CLS_BRANCH;
      c_OP_JALR: instr_class = (simm7 != 7'd0) ? CLS_HALT : CLS_JALR;
      default:   instr_class = CLS_ALU_RRR;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module : control_unit
// Brief  : Multicycle FETCH/DECODE/EXEC/MEM/WB controller for the 16-bit
//          RiSC-16-style datapath with a request/ready memory handshake.
//          Optional macro CTRL_PERF_EN enables the retired-instruction
//          counter; when undefined instr_retired is tied to zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction,
  input  logic        alu_eq,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        MUX_addr,
  output logic        WE_ir,
  output logic        WE_pc,
  output logic [1:0]  MUX_pc,
  output logic [1:0]  MUX_tgt,
  output logic        MUX_rf,
  output logic        WE_rf,
  output logic        MUX_alu_b,
  output logic        MUX_imm,
  output logic [1:0]  alu_op,
  output logic        halt,
  output logic [15:0] instr_retired
);

  state_t       r_state;
  state_t       w_next_state;
  instr_class_t w_class;
  logic [2:0]   w_opcode;
  logic [1:0]   w_alu_op;
  logic         w_alu_b;
  logic         w_imm;
  logic         w_rf;
  logic         w_alu_class;
  logic         w_unused_fields;

  assign w_opcode        = instruction[15:13];
  // Register index fields are consumed by the register file, not here
  assign w_unused_fields = ^instruction[12:7];

  instr_decode u_instr_decode (
    .opcode      (w_opcode),
    .simm7       (instruction[6:0]),
    .instr_class (w_class)
  );

  assign w_alu_class = (w_class == CLS_ALU_RRR) || (w_class == CLS_ALU_IMM) ||
                       (w_class == CLS_LUI);

  // ALU controls for the current instruction, reused in EXEC, MEM and WB
  always_comb begin
    w_alu_op = c_ALU_ADD;
    w_alu_b  = 1'b0;
    w_imm    = 1'b0;
    w_rf     = 1'b0;
    case (w_class)
      CLS_ALU_RRR: w_alu_op = (w_opcode == c_OP_NAND) ? c_ALU_NAND : c_ALU_ADD;
      CLS_ALU_IMM,
      CLS_LOAD,
      CLS_STORE:   w_alu_b = 1'b1;
      CLS_LUI: begin
        w_alu_op = c_ALU_PASS_B;
        w_alu_b  = 1'b1;
        w_imm    = 1'b1;
      end
      CLS_BRANCH: begin
        w_alu_op = c_ALU_EQ;
        w_rf     = 1'b1;
      end
      default: ;
    endcase
  end

  // State register; reset abandons any outstanding request immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next_state;
  end

  // Next state and datapath controls; everything is forced low during reset
  always_comb begin
    w_next_state = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    MUX_addr     = 1'b0;
    WE_ir        = 1'b0;
    WE_pc        = 1'b0;
    MUX_pc       = c_PC_INC;
    MUX_tgt      = c_TGT_MEM;
    MUX_rf       = 1'b0;
    WE_rf        = 1'b0;
    MUX_alu_b    = 1'b0;
    MUX_imm      = 1'b0;
    alu_op       = c_ALU_ADD;
    halt         = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            WE_ir        = 1'b1;
            w_next_state = S_DECODE;
          end
        end
        S_DECODE: w_next_state = (w_class == CLS_HALT) ? S_HALT : S_EXEC;
        S_EXEC: begin
          alu_op    = w_alu_op;
          MUX_alu_b = w_alu_b;
          MUX_imm   = w_imm;
          MUX_rf    = w_rf;
          case (w_class)
            CLS_BRANCH: begin
              WE_pc        = 1'b1;
              MUX_pc       = alu_eq ? c_PC_BRANCH : c_PC_INC;
              w_next_state = S_FETCH;
            end
            CLS_LOAD,
            CLS_STORE: w_next_state = S_MEM;
            default:   w_next_state = S_WB;
          endcase
        end
        S_MEM: begin
          alu_op    = w_alu_op;
          MUX_alu_b = w_alu_b;
          MUX_imm   = w_imm;
          mem_req   = 1'b1;
          MUX_addr  = 1'b1;
          mem_we    = (w_class == CLS_STORE);
          MUX_rf    = 1'b1;
          if (mem_ready) begin
            if (w_class == CLS_STORE) begin
              WE_pc        = 1'b1;
              w_next_state = S_FETCH;
            end else begin
              w_next_state = S_WB;
            end
          end
        end
        S_WB: begin
          WE_rf        = 1'b1;
          WE_pc        = 1'b1;
          w_next_state = S_FETCH;
          if (w_class == CLS_LOAD)      MUX_tgt = c_TGT_MEM;
          else if (w_class == CLS_JALR) MUX_tgt = c_TGT_PC1;
          else                          MUX_tgt = c_TGT_ALU;
          MUX_pc = (w_class == CLS_JALR) ? c_PC_REG : c_PC_INC;
          if (w_alu_class) begin
            alu_op    = w_alu_op;
            MUX_alu_b = w_alu_b;
            MUX_imm   = w_imm;
          end
        end
        S_HALT: halt = 1'b1;
        default: w_next_state = S_FETCH;
      endcase
    end
  end

`ifdef CTRL_PERF_EN
  logic [15:0] r_instr_retired;

  // Count every PC update as one retired instruction; wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_instr_retired <= 16'd0;
    else if (WE_pc) r_instr_retired <= r_instr_retired + 16'd1;
  end

  assign instr_retired = r_instr_retired;
`else
  assign instr_retired = 16'd0;
`endif

endmodule

`default_nettype wire
